vec_mat_iter_ctrl: RTL and testbench

- Upstream sequencer for the 1x2-by-2x2 fixed-point multiplier stage.
- Accepts a row vector, a 2x2 matrix and an iteration count.
- Repeatedly drives the multiplier with the current vector and the fixed matrix, feeding each result back as the next vector: out = v·M^N.
- Returns the final vector through a valid/ready handshake. Used for state propagation and rotation chains.

---
 rtl/vec_mat_iter_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vec_mat_iter_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vec_mat_iter_ctrl.sv
// vec_mat_iter_ctrl: sequencer that drives an external 1x2-by-2x2 fixed-point
// multiplier N times, feeding each result back as the next vector, and
// returns v * M^N through a valid/ready handshake.
// The block does no arithmetic; every word passes through bit-exact.
// Optional build macro VEC_MAT_ITER_PERF_EN adds the perf_cycles output: a
// saturating count of busy cycles for the most recent job.
module vec_mat_iter_ctrl #(
  parameter int BIT_NUM  = 18,
  parameter int FRAC_NUM = 9,
  parameter int ITER_W   = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_NUM-1:0] vec_in_0,
  input  logic [BIT_NUM-1:0] vec_in_1,
  input  logic [BIT_NUM-1:0] mat_in_00,
  input  logic [BIT_NUM-1:0] mat_in_01,
  input  logic [BIT_NUM-1:0] mat_in_10,
  input  logic [BIT_NUM-1:0] mat_in_11,
  input  logic [ITER_W-1:0]  iter_num,
  output logic [BIT_NUM-1:0] m_A_00,
  output logic [BIT_NUM-1:0] m_A_01,
  output logic [BIT_NUM-1:0] m_B_00,
  output logic [BIT_NUM-1:0] m_B_01,
  output logic [BIT_NUM-1:0] m_B_10,
  output logic [BIT_NUM-1:0] m_B_11,
  input  logic [BIT_NUM-1:0] m_C_00,
  input  logic [BIT_NUM-1:0] m_C_01,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_NUM-1:0] out_0,
  output logic [BIT_NUM-1:0] out_1,
  output logic               busy
`ifdef VEC_MAT_ITER_PERF_EN
  ,
  output logic [15:0]        perf_cycles
`endif
);

  // FRAC_NUM only documents the multiplier's format; reject nonsense at elaboration.
  if (FRAC_NUM >= BIT_NUM) begin : g_bad_frac
    $error("vec_mat_iter_ctrl: FRAC_NUM must be smaller than BIT_NUM");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]         state;
  logic [ITER_W-1:0]  n_reg;
  logic [ITER_W-1:0]  cnt;
  logic [ITER_W-1:0]  cnt_nxt;
  logic               accept;
  logic               last_iter;
  logic               zero_iter;

  logic [BIT_NUM-1:0] vec_0, vec_1;
  logic [BIT_NUM-1:0] mat_00, mat_01, mat_10, mat_11;
  logic [BIT_NUM-1:0] res_0, res_1;

  // cnt stays below n_reg <= 2^ITER_W-1 inside a job, so cnt+1 never wraps.
  assign cnt_nxt   = cnt + ITER_W'(1);
  assign last_iter = (cnt_nxt == n_reg);
  assign zero_iter = (iter_num == '0);
  assign accept    = in_valid & in_ready;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  assign m_A_00 = vec_0;
  assign m_A_01 = vec_1;
  assign m_B_00 = mat_00;
  assign m_B_01 = mat_01;
  assign m_B_10 = mat_10;
  assign m_B_11 = mat_11;
  assign out_0  = res_0;
  assign out_1  = res_1;

  // Job sequencing: alternate ISSUE/CAPT once per multiplication, then hold in OUT.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= S_IDLE;
      n_reg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            n_reg <= iter_num;
            cnt   <= '0;
            state <= zero_iter ? S_OUT : S_ISSUE;
          end
        end
        S_ISSUE: state <= S_CAPT;
        S_CAPT: begin
          cnt   <= cnt_nxt;
          state <= last_iter ? S_OUT : S_ISSUE;
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Vector/matrix registers: loaded on accept, vector replaced by each captured product.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vec_0  <= '0;
      vec_1  <= '0;
      mat_00 <= '0;
      mat_01 <= '0;
      mat_10 <= '0;
      mat_11 <= '0;
    end else if (accept) begin
      vec_0  <= vec_in_0;
      vec_1  <= vec_in_1;
      mat_00 <= mat_in_00;
      mat_01 <= mat_in_01;
      mat_10 <= mat_in_10;
      mat_11 <= mat_in_11;
    end else if (state == S_CAPT) begin
      vec_0  <= m_C_00;
      vec_1  <= m_C_01;
    end
  end

  // Result registers: passthrough for N == 0, otherwise the last captured product.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      res_0 <= '0;
      res_1 <= '0;
    end else if (accept && zero_iter) begin
      res_0 <= vec_in_0;
      res_1 <= vec_in_1;
    end else if ((state == S_CAPT) && last_iter) begin
      res_0 <= m_C_00;
      res_1 <= m_C_01;
    end
  end

`ifdef VEC_MAT_ITER_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Busy-cycle counter: cleared on accept, counts the OUT handshake cycle, then idles.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= sat_inc(perf_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_vec_mat_iter_ctrl.sv
// Self-checking bench for vec_mat_iter_ctrl with a behavioural multiplier and
// an iterate-by-iterate reference of v * M^N.
module tb_vec_mat_iter_ctrl;
  localparam int BW = 18;
  localparam int FW = 9;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic          in_valid, in_ready;
  logic [BW-1:0] vec_in_0, vec_in_1;
  logic [BW-1:0] mat_in_00, mat_in_01, mat_in_10, mat_in_11;
  logic [IW-1:0] iter_num;
  logic [BW-1:0] m_A_00, m_A_01, m_B_00, m_B_01, m_B_10, m_B_11;
  logic [BW-1:0] m_C_00 = '0;
  logic [BW-1:0] m_C_01 = '0;
  logic          out_valid, out_ready, busy;
  logic [BW-1:0] out_0, out_1;
`ifdef VEC_MAT_ITER_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] ev0 [0:255];
  logic [BW-1:0] ev1 [0:255];

  always #5 clk = ~clk;

  vec_mat_iter_ctrl #(.BIT_NUM(BW), .FRAC_NUM(FW), .ITER_W(IW)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
    .vec_in_0(vec_in_0), .vec_in_1(vec_in_1),
    .mat_in_00(mat_in_00), .mat_in_01(mat_in_01),
    .mat_in_10(mat_in_10), .mat_in_11(mat_in_11),
    .iter_num(iter_num),
    .m_A_00(m_A_00), .m_A_01(m_A_01),
    .m_B_00(m_B_00), .m_B_01(m_B_01), .m_B_10(m_B_10), .m_B_11(m_B_11),
    .m_C_00(m_C_00), .m_C_01(m_C_01),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_0(out_0), .out_1(out_1), .busy(busy)
`ifdef VEC_MAT_ITER_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // One output column of the fixed-point product: (a0*b0 + a1*b1) >>> FW, wrapped to BW bits.
  function automatic logic [BW-1:0] mul_col(input logic [BW-1:0] a0, input logic [BW-1:0] a1,
                                             input logic [BW-1:0] b0, input logic [BW-1:0] b1);
    longint s;
    s = longint'($signed(a0)) * longint'($signed(b0)) + longint'($signed(a1)) * longint'($signed(b1));
    s = s >>> FW;
    return s[BW-1:0];
  endfunction

  // External multiplier: result registered one clock after A/B.
  always @(posedge clk) begin
    m_C_00 <= mul_col(m_A_00, m_A_01, m_B_00, m_B_10);
    m_C_01 <= mul_col(m_A_00, m_A_01, m_B_01, m_B_11);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; runs one job end to end.
  task automatic run_job(input logic [BW-1:0] v0, input logic [BW-1:0] v1,
                         input logic [BW-1:0] b00, input logic [BW-1:0] b01,
                         input logic [BW-1:0] b10, input logic [BW-1:0] b11,
                         input int n, input int hold);
    ev0[0] = v0;
    ev1[0] = v1;
    for (int i = 0; i < n; i++) begin
      ev0[i+1] = mul_col(ev0[i], ev1[i], b00, b10);
      ev1[i+1] = mul_col(ev0[i], ev1[i], b01, b11);
    end
    check("in_ready_idle", 64'(in_ready), 64'(1));
    vec_in_0 = v0;  vec_in_1 = v1;
    mat_in_00 = b00; mat_in_01 = b01; mat_in_10 = b10; mat_in_11 = b11;
    iter_num = IW'(n);
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2 * n; i++) begin
      @(negedge clk);
      check("busy_run", 64'(busy), 64'(1));
      check("in_ready_run", 64'(in_ready), 64'(0));
      check("out_valid_early", 64'(out_valid), 64'(0));
      check("m_A_00", 64'(m_A_00), 64'(ev0[i/2]));
      check("m_A_01", 64'(m_A_01), 64'(ev1[i/2]));
      check("m_B_00", 64'(m_B_00), 64'(b00));
      check("m_B_01", 64'(m_B_01), 64'(b01));
      check("m_B_10", 64'(m_B_10), 64'(b10));
      check("m_B_11", 64'(m_B_11), 64'(b11));
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      vec_in_0  = BW'($urandom);
      vec_in_1  = BW'($urandom);
      mat_in_00 = BW'($urandom);
      iter_num  = IW'($urandom);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check("out_valid", 64'(out_valid), 64'(1));
      check("out_0", 64'(out_0), 64'(ev0[n]));
      check("out_1", 64'(out_1), 64'(ev1[n]));
      check("in_ready_out", 64'(in_ready), 64'(0));
      check("busy_out", 64'(busy), 64'(1));
      out_ready = (h == hold);
      in_valid  = 1'b1;
      vec_in_0  = BW'($urandom);
      vec_in_1  = BW'($urandom);
      iter_num  = IW'($urandom);
    end
    @(negedge clk);
    check("out_valid_done", 64'(out_valid), 64'(0));
    check("busy_done", 64'(busy), 64'(0));
    check("in_ready_done", 64'(in_ready), 64'(1));
`ifdef VEC_MAT_ITER_PERF_EN
    check("perf_cycles", 64'(perf_cycles), 64'(2 * n + hold + 1));
`endif
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    arst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    vec_in_0 = '0; vec_in_1 = '0;
    mat_in_00 = '0; mat_in_01 = '0; mat_in_10 = '0; mat_in_11 = '0;
    iter_num = '0;
    #2 arst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_m_A_00", 64'(m_A_00), 64'(0));
    check("rst_m_B_11", 64'(m_B_11), 64'(0));
    check("rst_out_0", 64'(out_0), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    arst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Scale: M = 0.5*I, v=(1024,2048), N=2 -> (256,512)
    run_job(BW'(1024), BW'(2048), BW'(256), BW'(0), BW'(0), BW'(256), 2, 0);
    // Shear: N=3 -> (512,2048)
    run_job(BW'(512), BW'(512), BW'(512), BW'(512), BW'(0), BW'(512), 3, 0);
    check("shear_out_1", 64'(ev1[3]), 64'(2048));
    // Passthrough: N=0
    run_job(BW'(7), BW'(-3), BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom), 0, 0);
    // Back-pressure with a job offered during the stall, then taken right after
    run_job(BW'($urandom), BW'($urandom), BW'(300), BW'(-100), BW'(50), BW'(400), 2, 5);
    run_job(BW'($urandom), BW'($urandom), BW'(512), BW'(0), BW'(0), BW'(512), 1, 0);

    // Reset during CAPT of an N=5 job
    vec_in_0 = BW'(1000); vec_in_1 = BW'(2000);
    mat_in_00 = BW'(512); mat_in_01 = BW'(7); mat_in_10 = BW'(9); mat_in_11 = BW'(512);
    iter_num = IW'(5);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("abort_m_A_00", 64'(m_A_00), 64'(0));
    check("abort_m_A_01", 64'(m_A_01), 64'(0));
    check("abort_m_B_00", 64'(m_B_00), 64'(0));
    check("abort_out_0", 64'(out_0), 64'(0));
    check("abort_out_1", 64'(out_1), 64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'(1));
    run_job(BW'(1000), BW'(2000), BW'(512), BW'(7), BW'(9), BW'(512), 5, 1);

    // Maximum iteration count with identity matrix
    run_job(BW'(12345), BW'(-777), BW'(512), BW'(0), BW'(0), BW'(512), 255, 0);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      run_job(BW'($urandom), BW'($urandom),
              BW'($urandom_range(0, 1023)), BW'($urandom), BW'($urandom), BW'($urandom_range(0, 1023)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
